// File: rtl/taxi_axil_timeout_pkg.sv
// Shared FSM state and AXI response codes for the AXI4-lite watchdog.
// TAXI_AXIL_TIMEOUT_DECERR_EN selects DECERR instead of SLVERR for locally generated errors.
package taxi_axil_timeout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    ORPHAN_RESP,
    ORPHAN
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef TAXI_AXIL_TIMEOUT_DECERR_EN
  localparam logic [1:0] RESP_ERR = RESP_DECERR;
`else
  localparam logic [1:0] RESP_ERR = RESP_SLVERR;
`endif

endpackage

// File: rtl/taxi_axil_if.sv
// AXI4-lite bundle with separate write/read modports for slave and master sides.
interface taxi_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport wr_slv (input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
                  output awready, wready, bresp, bvalid);
  modport wr_mst (output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
                  input awready, wready, bresp, bvalid);
  modport rd_slv (input araddr, arprot, arvalid, rready,
                  output arready, rdata, rresp, rvalid);
  modport rd_mst (output araddr, arprot, arvalid, rready,
                  input arready, rdata, rresp, rvalid);
endinterface

// File: rtl/taxi_axil_timeout_rd.sv
// Read-path watchdog: forwards one AR, errors out upstream with RD_ERR_DATA if R does not arrive in time.
// Late R responses are swallowed; reads arriving while orphaned are answered locally.
module taxi_axil_timeout_rd
  import taxi_axil_timeout_pkg::*;
#(
  parameter int          TIMEOUT     = 4096,
  parameter logic [63:0] RD_ERR_DATA = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  taxi_axil_if.rd_slv s,
  taxi_axil_if.rd_mst m,
  output logic        stat_timeout
);
  localparam int AW = s.ADDR_W;
  localparam int DW = s.DATA_W;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] ERR_DATA = RD_ERR_DATA[DW-1:0];

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          arv, arv_n, rv, rv_n, late, late_n, stat, stat_n;
  logic [1:0]    rresp, rresp_n;
  logic [DW-1:0] rdata, rdata_n;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          ar_hs, r_hs, tmo;

  always_comb begin
    s.arready = !rst && (state == IDLE || (state == ORPHAN && !rv));
    ar_hs    = s.arvalid && s.arready;
    m.rready = !rst && (state == WAIT || ((state == ORPHAN_RESP || state == ORPHAN) && !late));
    r_hs     = m.rvalid && m.rready;
    tmo      = (cnt == CW'(TIMEOUT - 1));

    state_n = state;
    cnt_n   = cnt;
    arv_n   = arv && !m.arready;
    rv_n    = rv;
    rresp_n = rresp;
    rdata_n = rdata;
    late_n  = late;
    stat_n  = 1'b0;

    case (state)
      IDLE: if (ar_hs) begin
        state_n = ISSUE;
        cnt_n   = '0;
        arv_n   = 1'b1;
      end
      ISSUE, WAIT: begin
        cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
        if (r_hs) begin
          rv_n    = 1'b1;
          rresp_n = m.rresp;
          rdata_n = m.rdata;
          state_n = RESP;
        end else if (tmo) begin
          rv_n    = 1'b1;
          rresp_n = RESP_ERR;
          rdata_n = ERR_DATA;
          stat_n  = 1'b1;
          state_n = ORPHAN_RESP;
        end else if (state == ISSUE && !arv_n) begin
          state_n = WAIT;
        end
      end
      RESP: if (s.rready) begin
        rv_n    = 1'b0;
        state_n = IDLE;
      end
      ORPHAN_RESP: begin
        late_n = late | r_hs;
        if (s.rready) begin
          rv_n    = 1'b0;
          state_n = ORPHAN;
        end
      end
      ORPHAN: begin
        late_n = late | r_hs;
        if (rv) begin
          if (s.rready) rv_n = 1'b0;
        end else if (ar_hs) begin
          rv_n    = 1'b1;
          rresp_n = RESP_ERR;
          rdata_n = ERR_DATA;
        end else if (late_n && !arv_n) begin
          late_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      arv   <= 1'b0;
      rv    <= 1'b0;
      rresp <= RESP_OKAY;
      rdata <= '0;
      late  <= 1'b0;
      stat  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      arv   <= arv_n;
      rv    <= rv_n;
      rresp <= rresp_n;
      rdata <= rdata_n;
      late  <= late_n;
      stat  <= stat_n;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs && state == IDLE) begin
      araddr <= s.araddr;
      arprot <= s.arprot;
    end
  end

  assign m.araddr     = araddr;
  assign m.arprot     = arprot;
  assign m.arvalid    = arv;
  assign s.rvalid     = rv;
  assign s.rresp      = rresp;
  assign s.rdata      = rdata;
  assign stat_timeout = stat;
endmodule

// File: rtl/taxi_axil_timeout_wr.sv
// Write-path watchdog: forwards one AW/W pair, errors out upstream if B does not arrive in time.
// Late B responses are swallowed; pairs arriving while orphaned are answered locally.
module taxi_axil_timeout_wr
  import taxi_axil_timeout_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  taxi_axil_if.wr_slv s,
  taxi_axil_if.wr_mst m,
  output logic        stat_timeout
);
  localparam int AW = s.ADDR_W;
  localparam int DW = s.DATA_W;
  localparam int SW = s.STRB_W;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            aw_cap, aw_cap_n, w_cap, w_cap_n;
  logic            awv, awv_n, wv, wv_n, bv, bv_n, late, late_n, stat, stat_n;
  logic [1:0]      bresp, bresp_n;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic [DW-1:0]   wdata;
  logic [SW-1:0]   wstrb;
  logic            accept, aw_hs, w_hs, b_hs, both, tmo;

  always_comb begin
    accept   = !rst && (state == IDLE || (state == ORPHAN && !bv));
    s.awready = accept && !aw_cap;
    s.wready  = accept && !w_cap;
    aw_hs    = s.awvalid && s.awready;
    w_hs     = s.wvalid && s.wready;
    m.bready = !rst && (state == WAIT || ((state == ORPHAN_RESP || state == ORPHAN) && !late));
    b_hs     = m.bvalid && m.bready;
    tmo      = (cnt == CW'(TIMEOUT - 1));

    state_n  = state;
    cnt_n    = cnt;
    aw_cap_n = aw_cap | aw_hs;
    w_cap_n  = w_cap | w_hs;
    awv_n    = awv && !m.awready;
    wv_n     = wv && !m.wready;
    bv_n     = bv;
    bresp_n  = bresp;
    late_n   = late;
    stat_n   = 1'b0;
    both     = aw_cap_n && w_cap_n;

    case (state)
      IDLE: if (both) begin
        state_n  = ISSUE;
        cnt_n    = '0;
        awv_n    = 1'b1;
        wv_n     = 1'b1;
        aw_cap_n = 1'b0;
        w_cap_n  = 1'b0;
      end
      ISSUE, WAIT: begin
        cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
        // A response completing on the timeout cycle takes priority over the error.
        if (b_hs) begin
          bv_n    = 1'b1;
          bresp_n = m.bresp;
          state_n = RESP;
        end else if (tmo) begin
          bv_n    = 1'b1;
          bresp_n = RESP_ERR;
          stat_n  = 1'b1;
          state_n = ORPHAN_RESP;
        end else if (state == ISSUE && !awv_n && !wv_n) begin
          state_n = WAIT;
        end
      end
      RESP: if (s.bready) begin
        bv_n    = 1'b0;
        state_n = IDLE;
      end
      ORPHAN_RESP: begin
        late_n = late | b_hs;
        if (s.bready) begin
          bv_n    = 1'b0;
          state_n = ORPHAN;
        end
      end
      ORPHAN: begin
        late_n = late | b_hs;
        if (bv) begin
          if (s.bready) bv_n = 1'b0;
        end else if (both) begin
          bv_n     = 1'b1;
          bresp_n  = RESP_ERR;
          aw_cap_n = 1'b0;
          w_cap_n  = 1'b0;
        end else if (late_n && !aw_cap_n && !w_cap_n && !awv_n && !wv_n) begin
          late_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      aw_cap <= 1'b0;
      w_cap  <= 1'b0;
      awv    <= 1'b0;
      wv     <= 1'b0;
      bv     <= 1'b0;
      bresp  <= RESP_OKAY;
      late   <= 1'b0;
      stat   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      aw_cap <= aw_cap_n;
      w_cap  <= w_cap_n;
      awv    <= awv_n;
      wv     <= wv_n;
      bv     <= bv_n;
      bresp  <= bresp_n;
      late   <= late_n;
      stat   <= stat_n;
    end
  end

  // Payload only loads in IDLE so a pending orphaned request is never disturbed.
  always_ff @(posedge clk) begin
    if (aw_hs && state == IDLE) begin
      awaddr <= s.awaddr;
      awprot <= s.awprot;
    end
    if (w_hs && state == IDLE) begin
      wdata <= s.wdata;
      wstrb <= s.wstrb;
    end
  end

  assign m.awaddr     = awaddr;
  assign m.awprot     = awprot;
  assign m.awvalid    = awv;
  assign m.wdata      = wdata;
  assign m.wstrb      = wstrb;
  assign m.wvalid     = wv;
  assign s.bvalid     = bv;
  assign s.bresp      = bresp;
  assign stat_timeout = stat;
endmodule

// File: rtl/taxi_axil_timeout.sv
// AXI4-lite transaction watchdog guarding a slave that may hang; independent write and read paths.
// TAXI_AXIL_TIMEOUT_DECERR_EN switches locally generated error responses from SLVERR to DECERR.
module taxi_axil_timeout #(
  parameter int          TIMEOUT     = 4096,
  parameter logic [63:0] RD_ERR_DATA = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  taxi_axil_if.wr_slv s_axil_wr,
  taxi_axil_if.rd_slv s_axil_rd,
  taxi_axil_if.wr_mst m_axil_wr,
  taxi_axil_if.rd_mst m_axil_rd,
  output logic        stat_wr_timeout,
  output logic        stat_rd_timeout
);
  taxi_axil_timeout_wr #(
    .TIMEOUT (TIMEOUT)
  ) u_wr (
    .clk          (clk),
    .rst          (rst),
    .s            (s_axil_wr),
    .m            (m_axil_wr),
    .stat_timeout (stat_wr_timeout)
  );

  taxi_axil_timeout_rd #(
    .TIMEOUT     (TIMEOUT),
    .RD_ERR_DATA (RD_ERR_DATA)
  ) u_rd (
    .clk          (clk),
    .rst          (rst),
    .s            (s_axil_rd),
    .m            (m_axil_rd),
    .stat_timeout (stat_rd_timeout)
  );
endmodule
